// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: single-outstanding read master with redirect,
// stale-response discard and a one-entry skid buffer toward the decoder.
module rv32i_fetch #(
   parameter logic [31:0] RV32I_RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] RV32I_NOP          = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        update_pc,
   input  logic [31:0] new_pc,
   input  logic        stall,
   output logic [31:0] imem_address,
   output logic        imem_read,
   input  logic        imem_waitrequest,
   input  logic [31:0] imem_readdata,
   input  logic        imem_readdatavalid,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        misaligned
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DISCARD
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_fpc;
   logic        r_stale;
   logic [31:0] r_hold_addr;
   logic        r_skid_valid;
   logic [31:0] r_skid_word;
   logic [31:0] r_skid_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic        r_misaligned;
   logic        w_read;
   logic        w_accept;
   logic        w_capture;
   logic        w_stale_set;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_REQ;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_read    = 1'b0;
      w_accept  = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         S_REQ: begin
            w_read   = ~r_skid_valid;
            w_accept = w_read & ~imem_waitrequest;
            if (w_accept) w_next = (r_stale | update_pc) ? S_DISCARD : S_WAIT;
         end
         S_WAIT: begin
            if (imem_readdatavalid) begin
               w_next    = S_REQ;
               w_capture = ~update_pc;
            end else if (update_pc) begin
               w_next = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (imem_readdatavalid) w_next = S_REQ;
         end
         default: w_next = S_REQ;
      endcase
   end

   // A redirect against a read the memory has not yet accepted must keep the
   // presented address stable; the response to it is discarded later.
   assign w_stale_set  = w_read & imem_waitrequest & update_pc;
   assign imem_read    = w_read;
   assign imem_address = r_stale ? r_hold_addr : r_fpc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fpc        <= RV32I_RESET_VECTOR;
         r_stale      <= 1'b0;
         r_hold_addr  <= '0;
         r_skid_valid <= 1'b0;
         r_skid_word  <= '0;
         r_skid_pc    <= '0;
         r_instr      <= RV32I_NOP;
         r_pc         <= RV32I_RESET_VECTOR;
         r_misaligned <= 1'b0;
      end else begin
         r_misaligned <= update_pc & (|new_pc[1:0]);

         if (update_pc)      r_fpc <= {new_pc[31:2], 2'b00};
         else if (w_capture) r_fpc <= r_fpc + 32'd4;

         if (w_accept)         r_stale <= 1'b0;
         else if (w_stale_set) r_stale <= 1'b1;

         if (w_stale_set && !r_stale) r_hold_addr <= r_fpc;

         if (update_pc) begin
            r_instr      <= RV32I_NOP;
            r_skid_valid <= 1'b0;
         end else if (!stall) begin
            if (r_skid_valid) begin
               r_instr      <= r_skid_word;
               r_pc         <= r_skid_pc;
               r_skid_valid <= 1'b0;
            end else if (w_capture) begin
               r_instr <= imem_readdata;
               r_pc    <= r_fpc;
            end else begin
               r_instr <= RV32I_NOP;
            end
         end else if (w_capture) begin
            r_skid_valid <= 1'b1;
            r_skid_word  <= imem_readdata;
            r_skid_pc    <= r_fpc;
         end
      end
   end

   assign instr      = r_instr;
   assign pc         = r_pc;
   assign misaligned = r_misaligned;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Directed bench for rv32i_fetch; memory handshakes are driven by hand per step.
module tb_rv32i_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        update_pc;
   logic [31:0] new_pc;
   logic        stall;
   logic [31:0] imem_address;
   logic        imem_read;
   logic        imem_waitrequest;
   logic [31:0] imem_readdata;
   logic        imem_readdatavalid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        misaligned;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   rv32i_fetch #(
      .RV32I_RESET_VECTOR(32'h0000_0000),
      .RV32I_NOP         (NOP)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .update_pc         (update_pc),
      .new_pc            (new_pc),
      .stall             (stall),
      .imem_address      (imem_address),
      .imem_read         (imem_read),
      .imem_waitrequest  (imem_waitrequest),
      .imem_readdata     (imem_readdata),
      .imem_readdatavalid(imem_readdatavalid),
      .instr             (instr),
      .pc                (pc),
      .misaligned        (misaligned)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      reset = 1'b1; update_pc = 1'b0; new_pc = '0; stall = 1'b0;
      imem_waitrequest = 1'b1; imem_readdata = '0; imem_readdatavalid = 1'b0;
      step(); step();
      chk("rst_instr", instr, NOP);
      chk("rst_pc", pc, 32'h0);
      chk("rst_read", {31'b0, imem_read}, 32'h1);
      chk("rst_addr", imem_address, 32'h0);
      chk("rst_mis", {31'b0, misaligned}, 32'h0);

      // zero-wait fetch at 0x0
      reset = 1'b0; imem_waitrequest = 1'b0;
      step();
      chk("f0_instr_nop", instr, NOP);
      chk("f0_read_wait", {31'b0, imem_read}, 32'h0);
      imem_readdatavalid = 1'b1; imem_readdata = 32'h0010_0093;
      step();
      imem_readdatavalid = 1'b0;
      chk("f0_instr", instr, 32'h0010_0093);
      chk("f0_pc", pc, 32'h0);
      chk("f0_next_addr", imem_address, 32'h4);
      chk("f0_next_read", {31'b0, imem_read}, 32'h1);
      step();
      chk("f1_bubble", instr, NOP);
      chk("f1_pc_hold", pc, 32'h0);

      // stall while the 0x4 response arrives: word parks in the skid buffer
      stall = 1'b1; imem_readdatavalid = 1'b1; imem_readdata = 32'hAAAA_0013;
      step();
      imem_readdatavalid = 1'b0;
      chk("st1_instr", instr, NOP);
      chk("st1_pc", pc, 32'h0);
      chk("st1_read", {31'b0, imem_read}, 32'h0);
      step();
      chk("st2_read", {31'b0, imem_read}, 32'h0);
      step();
      chk("st3_instr", instr, NOP);
      chk("st3_read", {31'b0, imem_read}, 32'h0);
      stall = 1'b0;
      step();
      chk("st_rel_instr", instr, 32'hAAAA_0013);
      chk("st_rel_pc", pc, 32'h4);
      chk("st_rel_addr", imem_address, 32'h8);
      chk("st_rel_read", {31'b0, imem_read}, 32'h1);
      step();
      chk("st_after_nop", instr, NOP);

      // redirect to 0x100 while waiting on 0x8
      update_pc = 1'b1; new_pc = 32'h100;
      step();
      update_pc = 1'b0;
      chk("rd1_read", {31'b0, imem_read}, 32'h0);
      chk("rd1_instr", instr, NOP);
      imem_readdatavalid = 1'b1; imem_readdata = 32'hDEAD_BEEF;
      step();
      imem_readdatavalid = 1'b0;
      chk("rd1_drop", instr, NOP);
      chk("rd1_addr", imem_address, 32'h100);
      chk("rd1_req", {31'b0, imem_read}, 32'h1);
      step();
      imem_readdatavalid = 1'b1; imem_readdata = 32'h1111_1113;
      step();
      imem_readdatavalid = 1'b0;
      chk("rd1_instr_new", instr, 32'h1111_1113);
      chk("rd1_pc_new", pc, 32'h100);
      chk("rd1_addr_next", imem_address, 32'h104);

      // accept 0x104, then redirect to 0xC on the same cycle its response arrives
      step();
      update_pc = 1'b1; new_pc = 32'hC; imem_readdatavalid = 1'b1; imem_readdata = 32'hBAD0_0001;
      step();
      update_pc = 1'b0; imem_readdatavalid = 1'b0;
      chk("rd2_drop", instr, NOP);
      chk("rd2_pc_hold", pc, 32'h100);
      chk("rd2_addr", imem_address, 32'hC);
      chk("rd2_read", {31'b0, imem_read}, 32'h1);

      // redirect to 0x200 while the 0xC read is not yet accepted
      imem_waitrequest = 1'b1; update_pc = 1'b1; new_pc = 32'h200;
      step();
      update_pc = 1'b0;
      chk("sh1_addr", imem_address, 32'hC);
      chk("sh1_read", {31'b0, imem_read}, 32'h1);
      step();
      chk("sh2_addr", imem_address, 32'hC);
      imem_waitrequest = 1'b0;
      step();
      chk("sh_acc_read", {31'b0, imem_read}, 32'h0);
      imem_readdatavalid = 1'b1; imem_readdata = 32'hBAD0_000C;
      step();
      imem_readdatavalid = 1'b0;
      chk("sh_drop", instr, NOP);
      chk("sh_addr_new", imem_address, 32'h200);
      chk("sh_read_new", {31'b0, imem_read}, 32'h1);
      step();
      imem_readdatavalid = 1'b1; imem_readdata = 32'h2222_2213;
      step();
      imem_readdatavalid = 1'b0;
      chk("sh_instr", instr, 32'h2222_2213);
      chk("sh_pc", pc, 32'h200);

      // misaligned redirect to 0x102 during WAIT at 0x204
      step();
      update_pc = 1'b1; new_pc = 32'h102;
      step();
      update_pc = 1'b0;
      chk("mis_pulse", {31'b0, misaligned}, 32'h1);
      imem_readdatavalid = 1'b1; imem_readdata = 32'hBAD0_0204;
      step();
      imem_readdatavalid = 1'b0;
      chk("mis_clear", {31'b0, misaligned}, 32'h0);
      chk("mis_addr", imem_address, 32'h100);
      chk("mis_drop", instr, NOP);

      // reset while waiting on 0x100
      step();
      chk("wr_read", {31'b0, imem_read}, 32'h0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("wr_instr", instr, NOP);
      chk("wr_pc", pc, 32'h0);
      chk("wr_read_after", {31'b0, imem_read}, 32'h1);
      chk("wr_addr", imem_address, 32'h0);

      // fetch PC wraps past the top of the address space
      step();
      update_pc = 1'b1; new_pc = 32'hFFFF_FFFC;
      step();
      update_pc = 1'b0; imem_readdatavalid = 1'b1; imem_readdata = 32'hBAD0_0000;
      step();
      imem_readdatavalid = 1'b0;
      chk("wrap_addr", imem_address, 32'hFFFF_FFFC);
      step();
      imem_readdatavalid = 1'b1; imem_readdata = 32'h3333_3313;
      step();
      imem_readdatavalid = 1'b0;
      chk("wrap_instr", instr, 32'h3333_3313);
      chk("wrap_pc", pc, 32'hFFFF_FFFC);
      chk("wrap_next", imem_address, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rv32i_fetch.md
RV32I_FETCH -- requirements
Module: rv32i_fetch

Interface
REQ-001 Parameter RV32I_RESET_VECTOR, default 32'h00000000, first fetch address after reset.
REQ-002 Parameter RV32I_NOP, default 32'h00000013 (ADDI x0,x0,0), bubble instruction word.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 update_pc  input  1  redirect request from ALU (taken branch/jump/trap).
REQ-006 new_pc  input  32  redirect target, sampled when update_pc=1.
REQ-007 stall  input  1  decoder/pipeline hold; instr/pc must not advance.
REQ-008 imem_address  output  32  instruction memory word address (bits [1:0] always 0).
REQ-009 imem_read  output  1  read request; held with stable address until accepted.
REQ-010 imem_waitrequest  input  1  request not accepted this cycle when 1.
REQ-011 imem_readdata  input  32  returned instruction word.
REQ-012 imem_readdatavalid  input  1  imem_readdata valid this cycle; one response per accepted read, in order.
REQ-013 instr  output  32  instruction word to decoder, registered.
REQ-014 pc  output  32  address of instr, registered.
REQ-015 misaligned  output  1  one-cycle pulse: redirect target had new_pc[1:0] != 0.

Function
REQ-016 At most one read outstanding; a read is accepted when imem_read=1 and imem_waitrequest=0.
REQ-017 States: REQ (imem_read=1), WAIT (await response), DISCARD (await and drop stale response); internal fetch PC fpc, stale flag, one-entry skid buffer (word + pc + valid).
REQ-018 REQ: on acceptance go WAIT, or DISCARD if stale=1 or update_pc=1 this cycle; while skid valid=1, imem_read is 0 and state remains REQ.
REQ-019 WAIT: on imem_readdatavalid with update_pc=0, capture word with pc=fpc, fpc <= fpc+4 (mod 2^32), go REQ.
REQ-020 DISCARD: on imem_readdatavalid drop the word, clear stale, go REQ.
REQ-021 Captured word goes to instr/pc on the next edge if stall=0, else into skid buffer.
REQ-022 When stall=0 and skid valid=1, skid contents go to instr/pc and skid clears; a simultaneous new capture is impossible (REQ-018).
REQ-023 Every edge with stall=0 and no word delivered, instr <= RV32I_NOP, pc holds; no word is ever presented twice.
REQ-024 stall=1: instr and pc hold their values.
REQ-025 update_pc=1 (highest priority, any state, overrides stall): fpc <= {new_pc[31:2],2'b00}; skid cleared; instr <= RV32I_NOP; any same-cycle imem_readdatavalid dropped.
REQ-026 update_pc in WAIT without same-cycle response: go DISCARD; with same-cycle response: go REQ.
REQ-027 update_pc in REQ while imem_waitrequest=1: imem_address stays at the old value until accepted, stale <= 1; new fpc issued in the following REQ.
REQ-028 update_pc in DISCARD: fpc updated, state unchanged unless response present (then REQ).
REQ-029 misaligned <= update_pc & |new_pc[1:0]; 0 otherwise.
REQ-030 imem_address = fpc in REQ, except during stale hold (REQ-027).

Reset
REQ-031 reset=1: state REQ, fpc=RV32I_RESET_VECTOR, stale=0, skid valid=0, instr=RV32I_NOP, pc=RV32I_RESET_VECTOR, misaligned=0; overrides all inputs including mid-WAIT.
REQ-032 Instruction memory shares reset; no response arrives for a read accepted before reset.

Verification
REQ-033 Reset, zero-wait memory, readdata 32'h00100093 at 0x0 -> imem_address=0x0, instr=NOP until response, then instr=32'h00100093 pc=0x0, next imem_address=0x4.
REQ-034 stall=1 for 3 cycles while response 32'hAAAA0013 arrives -> instr/pc unchanged, imem_read=0 while skid full; after stall drops, instr=32'hAAAA0013 next edge, then NOP.
REQ-035 update_pc=1 new_pc=0x100 during WAIT at 0x8 -> response for 0x8 never reaches instr; next accepted address 0x100; instr for 0x100 has pc=0x100.
REQ-036 update_pc new_pc=0x200 with imem_waitrequest=1 at 0xC -> imem_address stays 0xC until accepted, that response dropped, then read 0x200.
REQ-037 update_pc new_pc=0x102 -> misaligned=1 for exactly one cycle, next fetch address 0x100.
REQ-038 reset asserted in WAIT -> next cycle instr=NOP, pc=0x0, imem_read=1, imem_address=0x0.
